// File: rtl/pattern_matcher.sv
// Naive byte-pattern search over two 1-cycle-latency BRAMs. Reports every
// (possibly overlapping) match offset and a saturating count.
module pattern_matcher (
  input  logic       clka,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data_len,
  input  logic [7:0] pat_len,
  input  logic [7:0] data_byte,
  input  logic [7:0] pattern_byte,
  output logic       bram_en,
  output logic [7:0] data_addr,
  output logic [7:0] pat_addr,
  output logic       busy,
  output logic       match_valid,
  output logic [7:0] match_addr,
  output logic [7:0] match_count,
  output logic       done
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_COMPARE, S_DONE} state_t;

  state_t     state, state_nx;
  logic [7:0] i, j, dlen, plen;
  logic       start_ok, hit, last_j, last_i;

  always_comb begin
    start_ok = start && (pat_len != 8'd0) && (pat_len <= data_len);
    hit      = (data_byte == pattern_byte);
    last_j   = (j == plen - 8'd1);
    last_i   = (i == dlen - plen);
  end

  always_ff @(posedge clka) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:    if (start) state_nx = start_ok ? S_FETCH : S_DONE;
      S_FETCH:   state_nx = S_COMPARE;
      S_COMPARE: begin
        if (hit && !last_j) state_nx = S_FETCH;
        else if (last_i)    state_nx = S_DONE;
        else                state_nx = S_FETCH;
      end
      S_DONE:    state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    busy    = (state == S_FETCH) || (state == S_COMPARE);
    bram_en = busy;
    done    = (state == S_DONE);
  end

  // Addresses are loaded alongside i/j so they already hold i+j / j while in FETCH.
  always_ff @(posedge clka) begin
    if (rst) begin
      i           <= '0;
      j           <= '0;
      dlen        <= '0;
      plen        <= '0;
      data_addr   <= '0;
      pat_addr    <= '0;
      match_valid <= 1'b0;
      match_addr  <= '0;
      match_count <= '0;
    end else begin
      match_valid <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            match_count <= '0;
            match_addr  <= '0;
            if (start_ok) begin
              dlen      <= data_len;
              plen      <= pat_len;
              i         <= '0;
              j         <= '0;
              data_addr <= '0;
              pat_addr  <= '0;
            end
          end
        end
        S_COMPARE: begin
          if (hit && !last_j) begin
            j         <= j + 8'd1;
            data_addr <= i + j + 8'd1;
            pat_addr  <= j + 8'd1;
          end else begin
            if (hit) begin
              match_valid <= 1'b1;
              match_addr  <= i;
              if (match_count != 8'hFF) match_count <= match_count + 8'd1;
            end
            if (!last_i) begin
              i         <= i + 8'd1;
              j         <= '0;
              data_addr <= i + 8'd1;
              pat_addr  <= '0;
            end else begin
              data_addr <= '0;
              pat_addr  <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pattern_matcher.sv
// Directed bench for pattern_matcher with behavioural 1-cycle-latency BRAMs.
module tb_pattern_matcher;

  logic       clka = 1'b0;
  logic       rst, start;
  logic [7:0] data_len, pat_len, data_byte, pattern_byte;
  logic       bram_en, busy, match_valid, done;
  logic [7:0] data_addr, pat_addr, match_addr, match_count;

  pattern_matcher dut (
    .clka(clka), .rst(rst), .start(start), .data_len(data_len), .pat_len(pat_len),
    .data_byte(data_byte), .pattern_byte(pattern_byte), .bram_en(bram_en),
    .data_addr(data_addr), .pat_addr(pat_addr), .busy(busy), .match_valid(match_valid),
    .match_addr(match_addr), .match_count(match_count), .done(done)
  );

  always #5 clka = ~clka;

  logic [7:0] dmem [256];
  logic [7:0] pmem [256];

  always @(posedge clka) begin
    if (bram_en) begin
      data_byte    <= dmem[data_addr];
      pattern_byte <= pmem[pat_addr];
    end
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  int         got[$];
  int         done_cyc, busy_cyc, max_da;
  bit         en_seen;
  bit         busy_tr [16];
  bit         mv_tr   [16];
  logic [7:0] da_tr   [16];

  task automatic load(input string d, input string p);
    for (int k = 0; k < d.len(); k++) dmem[k] = d[k];
    for (int k = 0; k < p.len(); k++) pmem[k] = p[k];
  endtask

  // Cycle c is counted from the cycle after the one in which start is high.
  task automatic run(input int dl, input int pl, input int poke, input int limit);
    got.delete();
    done_cyc = 0; busy_cyc = 0; max_da = 0; en_seen = 0;
    for (int k = 0; k < 16; k++) begin busy_tr[k] = 0; mv_tr[k] = 0; da_tr[k] = '0; end
    @(negedge clka);
    data_len = 8'(dl); pat_len = 8'(pl); start = 1'b1;
    for (int c = 1; c <= limit; c++) begin
      @(negedge clka);
      if (c < 16) begin busy_tr[c] = busy; mv_tr[c] = match_valid; da_tr[c] = data_addr; end
      if (busy) busy_cyc++;
      if (bram_en) en_seen = 1;
      if (int'(data_addr) > max_da) max_da = int'(data_addr);
      if (match_valid) got.push_back(int'(match_addr));
      start = (c == poke);
      if (c == poke) pat_len = 8'd1;
      if (done) begin done_cyc = c; break; end
    end
    start = 1'b0;
    if (done_cyc == 0) check("done_timeout", 0, 1);
    @(negedge clka);
    check("done_one_cycle", {30'd0, done, busy}, 0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check(tag, {bram_en, busy, match_valid, done, data_addr, pat_addr, match_addr}, 0);
    check({tag, "_count"}, match_count, 0);
  endtask

  initial begin
    int bm, mm;
    rst = 1'b1; start = 1'b0; data_len = '0; pat_len = '0;
    repeat (2) @(negedge clka);
    check_idle_outputs("reset");
    rst = 1'b0;

    // ABCABCAB / ABC
    load("ABCABCAB", "ABC");
    run(8, 3, 0, 200);
    check("abc_nmatch", got.size(), 2);
    if (got.size() == 2) begin
      check("abc_addr0", got[0], 0);
      check("abc_addr1", got[1], 3);
    end
    check("abc_count", match_count, 2);

    // AAAA / AA overlapping, with an ignored start pulse mid-search
    load("AAAA", "AA");
    run(4, 2, 3, 200);
    check("aaaa_nmatch", got.size(), 3);
    if (got.size() == 3) begin
      check("aaaa_addr0", got[0], 0);
      check("aaaa_addr1", got[1], 1);
      check("aaaa_addr2", got[2], 2);
    end
    check("aaaa_count", match_count, 3);
    check("aaaa_busy", busy_cyc, 12);

    // XYZ / Y exact timing
    load("XYZ", "Y");
    run(3, 1, 0, 50);
    bm = 0; mm = 0;
    for (int c = 1; c <= 7; c++) begin
      bm |= int'(busy_tr[c]) << c;
      mm |= int'(mv_tr[c]) << c;
    end
    check("xyz_busy_mask", bm, 32'h7E);
    check("xyz_mv_mask", mm, 32'h20);
    check("xyz_done_cyc", done_cyc, 7);
    check("xyz_addr_c1", da_tr[1], 0);
    check("xyz_addr_c3", da_tr[3], 1);
    check("xyz_addr_c5", da_tr[5], 2);
    check("xyz_match_addr", got.size() == 1 ? got[0] : -1, 1);
    check("xyz_count", match_count, 1);

    // Degenerate lengths
    run(4, 5, 0, 20);
    check("long_pat_done_cyc", done_cyc, 1);
    check("long_pat_en", en_seen, 0);
    check("long_pat_count", match_count, 0);
    load("AAAA", "AA");
    run(4, 2, 0, 200);
    run(4, 0, 0, 20);
    check("zero_pat_done_cyc", done_cyc, 1);
    check("zero_pat_en", en_seen, 0);
    check("zero_pat_count", match_count, 0);

    // Full 255-byte buffer, identical contents
    for (int k = 0; k < 256; k++) begin
      dmem[k] = 8'(k * 7 + 3);
      pmem[k] = 8'(k * 7 + 3);
    end
    run(255, 255, 0, 700);
    check("big_nmatch", got.size(), 1);
    check("big_addr", got.size() == 1 ? got[0] : -1, 0);
    check("big_busy", busy_cyc, 510);
    check("big_max_addr", max_da, 254);
    check("big_done_cyc", done_cyc, 511);
    check("big_count", match_count, 1);

    // Reset mid-search
    load("ABCABCAB", "ABC");
    @(negedge clka);
    data_len = 8'd8; pat_len = 8'd3; start = 1'b1;
    @(negedge clka);
    check("rst_busy_c1", busy, 1);
    @(negedge clka);
    start = 1'b0; rst = 1'b1;
    @(negedge clka);
    rst = 1'b0;
    check_idle_outputs("rst_mid");
    bm = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clka);
      bm |= int'(done) | (int'(busy) << 1);
    end
    check("rst_quiet", bm, 0);
    run(8, 3, 0, 200);
    check("rst_rerun_nmatch", got.size(), 2);
    check("rst_rerun_count", match_count, 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pattern_matcher.md
PATTERN_MATCHER -- requirements
Module: pattern_matcher

Interface
REQ-001 SHALL have port: clka  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: rst  input  1  synchronous active-high reset, sampled on rising clka.
REQ-003 SHALL have port: start  input  1  request search; sampled only in IDLE.
REQ-004 SHALL have port: data_len  input  8  data buffer length in bytes; latched at accepted start.
REQ-005 SHALL have port: pat_len  input  8  pattern length in bytes; latched at accepted start.
REQ-006 SHALL have port: data_byte  input  8  data BRAM douta; fixed 1-cycle read latency.
REQ-007 SHALL have port: pattern_byte  input  8  pattern BRAM douta; fixed 1-cycle read latency.
REQ-008 SHALL have port: bram_en  output  1  ena to both BRAMs; wea is tied 0 outside this block.
REQ-009 SHALL have port: data_addr  output  8  registered addra to data BRAM.
REQ-010 SHALL have port: pat_addr  output  8  registered addra to pattern BRAM.
REQ-011 SHALL have port: busy  output  1  high in FETCH or COMPARE.
REQ-012 SHALL have port: match_valid  output  1  one-cycle pulse per match found.
REQ-013 SHALL have port: match_addr  output  8  data offset of match; valid with match_valid.
REQ-014 SHALL have port: match_count  output  8  matches found in current or last search.
REQ-015 SHALL have port: done  output  1  one-cycle pulse at search end.

Function
REQ-016 SHALL implement FSM states IDLE, FETCH, COMPARE, DONE; internal indices i (data offset) and j (pattern offset), 8 bits each.
REQ-017 SHALL, in IDLE with start=1 and 1<=pat_len<=data_len, latch lengths, clear match_count, set i=0, j=0, enter FETCH.
REQ-018 SHALL, in IDLE with start=1 and (pat_len=0 or pat_len>data_len), enter DONE directly with match_count=0 and no BRAM access.
REQ-019 SHALL drive data_addr=i+j and pat_addr=j throughout FETCH and the following COMPARE; bram_en=1 in FETCH and COMPARE, 0 otherwise.
REQ-020 SHALL, in COMPARE, compare data_byte with pattern_byte (data valid exactly one cycle after FETCH).
REQ-021 SHALL, on equality with j<pat_len-1: j<=j+1, next state FETCH.
REQ-022 SHALL, on equality with j=pat_len-1: register match_valid=1 and match_addr=i for the next cycle, match_count<=match_count+1, then advance.
REQ-023 SHALL, on inequality: advance (naive restart; overlapping matches are found).
REQ-024 SHALL, on advance: if i=data_len-pat_len enter DONE; else i<=i+1, j<=0, enter FETCH.
REQ-025 SHALL keep i+j<=254 so 8-bit address never wraps; match_count saturates at 255.
REQ-026 SHALL assert done for exactly the one cycle spent in DONE, then return to IDLE.
REQ-027 SHALL ignore start while not in IDLE; match_count and match_addr hold until next accepted start.

Reset
REQ-028 SHALL on rst=1 enter IDLE next cycle with bram_en, data_addr, pat_addr, busy, match_valid, match_addr, match_count, done all 0, regardless of current state; rst has priority over start.

Verification
REQ-029 data "ABCABCAB" (len 8), pattern "ABC" (len 3) -> match_valid pulses with match_addr 0 then 3; match_count=2 at done.
REQ-030 data "AAAA", pattern "AA" -> matches at 0,1,2; match_count=3 (overlap).
REQ-031 data "XYZ", pattern "Y", start high cycle 0 -> FETCH c1/c3/c5, COMPARE c2/c4/c6, match_valid c5 addr 1, done c7, busy c1-c6.
REQ-032 pat_len=5, data_len=4, start -> done next cycle, match_count=0, bram_en never high; pat_len=0 same.
REQ-033 data_len=pat_len=255, identical contents -> single match at addr 0 after 510 busy cycles; data_addr reaches 254, no wrap.
REQ-034 rst pulse during COMPARE of a search; start pulsed while busy -> second start ignored; after rst all outputs 0, no done; new start runs a clean search.
